// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    // {multiplier LSB, booth bit} pairs that require an add or a subtract.
    localparam logic [1:0] BoothAdd = 2'b01;
    localparam logic [1:0] BoothSub = 2'b10;

    // Counter must hold WIDTH+1, the number of Booth steps.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake and result bus for the Booth multiplier.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;

    // Requester side (control unit).
    modport master (
        output start, is_signed, op_a, op_b,
        input  ready, busy, done, hi, lo, ovf
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, op_a, op_b,
        output ready, busy, done, hi, lo, ovf
    );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub into the upper half,
// then arithmetic right shift of the whole accumulator.
module booth_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH+2:0] i_acc,
    input  logic [WIDTH:0]     i_mcand,
    output logic [2*WIDTH+2:0] o_acc
);

    logic [WIDTH:0] w_upper;
    logic [WIDTH:0] w_sum;

    // Select add/sub/none from the booth pair, then shift with sign fill.
    always_comb begin
        w_upper = i_acc[2*WIDTH+2:WIDTH+2];
        w_sum   = w_upper;
        case (i_acc[1:0])
            BoothAdd: w_sum = w_upper + i_mcand;
            BoothSub: w_sum = w_upper - i_mcand;
            default:  w_sum = w_upper;
        endcase
        o_acc = {w_sum[WIDTH], w_sum, i_acc[WIDTH+1:1]};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake,
// per-operation signed/unsigned mode and an overflow flag.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic             clock,
    input logic             reset,
    booth_mult_seq_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned XW    = WIDTH + 1;
    localparam int unsigned AW    = 2 * XW + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [AW-1:0]      r_acc;
    logic [AW-1:0]      w_acc_next;
    logic [XW-1:0]      r_mcand;
    logic               r_signed;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_ovf;

    logic               w_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_finish;
    logic               w_last;
    logic [XW-1:0]      w_ext_a;
    logic [XW-1:0]      w_ext_b;
    logic [WIDTH-1:0]   w_prod_hi;
    logic [WIDTH-1:0]   w_prod_lo;
    logic               w_ovf;

    assign w_ext_a   = {bus.is_signed & bus.op_a[WIDTH-1], bus.op_a};
    assign w_ext_b   = {bus.is_signed & bus.op_b[WIDTH-1], bus.op_b};
    assign w_last    = (r_cnt == CNT_W'(XW));
    // Product sits in acc[2*XW:1] once all steps are done; keep low 2*WIDTH bits.
    assign w_prod_hi = r_acc[2*WIDTH:WIDTH+1];
    assign w_prod_lo = r_acc[WIDTH:1];
    assign w_ovf     = r_signed ? (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}})
                                : (w_prod_hi != '0);

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_next)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Operand capture, Booth iterations and step counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= {{XW{1'b0}}, w_ext_b, 1'b0};
            r_mcand  <= w_ext_a;
            r_signed <= bus.is_signed;
        end else if (r_state == StRun && !w_last) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers; loaded on the edge entering DONE so they are valid with done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_ovf <= 1'b0;
        end else if (w_finish) begin
            r_hi  <= w_prod_hi;
            r_lo  <= w_prod_lo;
            r_ovf <= w_ovf;
        end
    end

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed checks of booth_mult_seq at WIDTH=32 plus a WIDTH=8 sweep against a model.
module tb_booth_mult_seq;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    booth_mult_seq_if #(.WIDTH(32)) if32 ();
    booth_mult_seq_if #(.WIDTH(8))  if8 ();

    booth_mult_seq #(.WIDTH(32)) u_dut32 (
        .clock (clock),
        .reset (reset),
        .bus   (if32.slave)
    );

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (if8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op on the 32-bit unit; lat counts edges from accept to the done cycle.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [31:0] h, output logic [31:0] l,
                         output logic o);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!if32.ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if32.start = 1'b1;
        if32.op_a = a;
        if32.op_b = b;
        if32.is_signed = s;
        @(posedge clock);
        #1;
        if32.start = 1'b0;
        if32.op_a = ~a;
        if32.op_b = ~b;
        if32.is_signed = ~s;
        lat = 0;
        @(negedge clock);
        while (!if32.done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        h = if32.hi;
        l = if32.lo;
        o = if32.ovf;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output logic [7:0] h, output logic [7:0] l,
                        output logic o);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!if8.ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if8.start = 1'b1;
        if8.op_a = a;
        if8.op_b = b;
        if8.is_signed = s;
        @(posedge clock);
        #1;
        if8.start = 1'b0;
        if8.op_a = 8'($urandom);
        if8.op_b = 8'($urandom);
        if8.is_signed = 1'($urandom);
        lat = 0;
        @(negedge clock);
        while (!if8.done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        h = if8.hi;
        l = if8.lo;
        o = if8.ovf;
    endtask

    task automatic test_reset();
        #3;
        checks += 6;
        if (if32.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if32.ready); end
        if (if32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", if32.busy); end
        if (if32.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", if32.done); end
        if (if32.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", if32.hi); end
        if (if32.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", if32.lo); end
        if (if32.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", if32.ovf); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed32();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vs [5];
        logic [31:0] eh [5];
        logic [31:0] el [5];
        logic        eo [5];
        int          lat;
        logic [31:0] h;
        logic [31:0] l;
        logic        o;
        va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD; vs[0] = 1'b1;
        eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFEB; eo[0] = 1'b0;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vs[1] = 1'b0;
        eh[1] = 32'hFFFFFFFE; el[1] = 32'h00000001; eo[1] = 1'b1;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; vs[2] = 1'b1;
        eh[2] = 32'h00000000; el[2] = 32'h00000001; eo[2] = 1'b0;
        va[3] = 32'h80000000; vb[3] = 32'h80000000; vs[3] = 1'b1;
        eh[3] = 32'h40000000; el[3] = 32'h00000000; eo[3] = 1'b1;
        va[4] = 32'h00000000; vb[4] = 32'h12345678; vs[4] = 1'b1;
        eh[4] = 32'h00000000; el[4] = 32'h00000000; eo[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run32(va[i], vb[i], vs[i], lat, h, l, o);
            checks += 4;
            if (lat !== 34) begin failures++; $display("FAIL d32_latency[%0d] got=%0d exp=34", i, lat); end
            if (h !== eh[i]) begin failures++; $display("FAIL d32_hi[%0d] got=%h exp=%h", i, h, eh[i]); end
            if (l !== el[i]) begin failures++; $display("FAIL d32_lo[%0d] got=%h exp=%h", i, l, el[i]); end
            if (o !== eo[i]) begin failures++; $display("FAIL d32_ovf[%0d] got=%b exp=%b", i, o, eo[i]); end
            // One-cycle done pulse, results hold afterwards.
            @(negedge clock);
            checks += 3;
            if (if32.done !== 1'b0) begin failures++; $display("FAIL d32_pulse[%0d] got=%b exp=0", i, if32.done); end
            if (if32.ready !== 1'b1) begin failures++; $display("FAIL d32_ready[%0d] got=%b exp=1", i, if32.ready); end
            if (if32.lo !== el[i]) begin failures++; $display("FAIL d32_hold[%0d] got=%h exp=%h", i, if32.lo, el[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int n2;
        logic [31:0] h;
        logic [31:0] l;
        @(negedge clock);
        if32.start = 1'b1;
        if32.op_a = 32'd3;
        if32.op_b = 32'd5;
        if32.is_signed = 1'b0;
        @(posedge clock);
        n = 0;
        @(negedge clock);
        while (!if32.done && n < 200) begin
            if32.op_a = $urandom;
            if32.op_b = $urandom;
            if32.is_signed = 1'($urandom);
            @(negedge clock);
            n++;
        end
        h = if32.hi;
        l = if32.lo;
        checks += 3;
        if (n !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", n); end
        if (h !== 32'd0) begin failures++; $display("FAIL b2b_hi got=%h exp=0", h); end
        if (l !== 32'd15) begin failures++; $display("FAIL b2b_lo got=%h exp=f", l); end
        // Start still held: it must be taken in the first IDLE cycle.
        if32.op_a = 32'h00010000;
        if32.op_b = 32'h00010000;
        if32.is_signed = 1'b0;
        @(negedge clock);
        checks += 2;
        if (if32.done !== 1'b0) begin failures++; $display("FAIL b2b_single_done got=%b exp=0", if32.done); end
        if (if32.ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", if32.ready); end
        @(negedge clock);
        if32.start = 1'b0;
        checks++;
        if (if32.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", if32.busy); end
        n2 = 0;
        while (!if32.done && n2 < 200) begin
            @(negedge clock);
            n2++;
        end
        checks += 4;
        if (n2 !== 34) begin failures++; $display("FAIL b2b2_latency got=%0d exp=34", n2); end
        if (if32.hi !== 32'd1) begin failures++; $display("FAIL b2b2_hi got=%h exp=1", if32.hi); end
        if (if32.lo !== 32'd0) begin failures++; $display("FAIL b2b2_lo got=%h exp=0", if32.lo); end
        if (if32.ovf !== 1'b1) begin failures++; $display("FAIL b2b2_ovf got=%b exp=1", if32.ovf); end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clock);
        @(negedge clock);
        if32.start = 1'b1;
        if32.op_a = 32'd9;
        if32.op_b = 32'd9;
        if32.is_signed = 1'b0;
        @(posedge clock);
        #1;
        if32.start = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks += 4;
        if (if32.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", if32.ready); end
        if (if32.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", if32.busy); end
        if (if32.hi !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", if32.hi); end
        if (if32.lo !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", if32.lo); end
        #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (if32.done) dones++;
        end
        checks += 2;
        if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        if (if32.ready !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", if32.ready); end
    endtask

    task automatic test_width8_model();
        int          lat;
        logic [7:0]  h;
        logic [7:0]  l;
        logic        o;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
        logic        eo;
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic        ts [4];
        ta[0] = 8'h80; tb[0] = 8'h80; ts[0] = 1'b1;
        ta[1] = 8'hFF; tb[1] = 8'hFF; ts[1] = 1'b0;
        ta[2] = 8'hFF; tb[2] = 8'hFF; ts[2] = 1'b1;
        ta[3] = 8'h7F; tb[3] = 8'h80; ts[3] = 1'b1;
        for (int i = 0; i < 1004; i++) begin
            if (i < 4) begin
                a = ta[i];
                b = tb[i];
                s = ts[i];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                s = 1'($urandom);
            end
            if (s) begin
                p  = 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
                eo = (p[15:8] != {8{p[7]}});
            end else begin
                p  = {8'h00, a} * {8'h00, b};
                eo = (p[15:8] != 8'h00);
            end
            run8(a, b, s, lat, h, l, o);
            checks += 4;
            if (lat !== 10) begin failures++; $display("FAIL w8_latency[%0d] got=%0d exp=10", i, lat); end
            if (h !== p[15:8]) begin failures++; $display("FAIL w8_hi[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, h, p[15:8]); end
            if (l !== p[7:0]) begin failures++; $display("FAIL w8_lo[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, l, p[7:0]); end
            if (o !== eo) begin failures++; $display("FAIL w8_ovf[%0d] a=%h b=%h s=%b got=%b exp=%b", i, a, b, s, o, eo); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        if32.start = 1'b0;
        if32.is_signed = 1'b0;
        if32.op_a = '0;
        if32.op_b = '0;
        if8.start = 1'b0;
        if8.is_signed = 1'b0;
        if8.op_a = '0;
        if8.op_b = '0;
        test_reset();
        test_directed32();
        test_back_to_back();
        test_reset_mid_run();
        test_width8_model();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
